des_key_sched: RTL and testbench

- Sequential DES key-schedule engine. Accepts one 64-bit key over a valid/ready handshake, applies PC-1, then streams the 16 round subkeys one at a time over a valid/ready output handshake.
- Each subkey is produced by rotating C/D and applying PC-2.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1) per key, plus optional odd-parity key checking.
- Feeds the round datapath of the DES core.

---
 rtl/des_pkg.sv | 65 ++++++
 rtl/des_key_sched_if.sv | 24 ++
 rtl/des_key_sched_pc2.sv | 9 +
 rtl/des_key_sched.sv | 108 ++++++++++
 tb/tb_des_key_sched.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants, permutation tables and bit-level helpers.
// Bit numbering follows DES convention: index 1 is the most significant bit.
package des_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] SHIFT [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int PC1 [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] r;
    for (int i = 1; i <= 56; i++) r[i] = k[PC1[i]];
    return r;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] r;
    for (int i = 1; i <= 48; i++) r[i] = cd[PC2[i]];
    return r;
  endfunction

  // Only shift amounts of 1 and 2 occur in the key schedule.
  function automatic logic [1:28] rotl28(input logic [1:28] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  function automatic logic [1:28] rotr28(input logic [1:28] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

  function automatic logic keyParityErr(input logic [1:64] k);
    logic err;
    err = 1'b0;
    for (int b = 0; b < 8; b++) err = err | ~(^k[8*b+1 +: 8]);
    return err;
  endfunction

endpackage

// File: rtl/des_key_sched_if.sv
// Key-load and subkey-stream handshake bundle for the DES key scheduler.
// The engine is the slave; the key source / round datapath is the master.
interface des_key_sched_if;
  logic        key_valid;
  logic        key_ready;
  logic [1:64] key_in;
  logic        key_decrypt;
  logic        sk_valid;
  logic        sk_ready;
  logic [1:48] subkey_out;
  logic [3:0]  sk_round;
  logic        sk_last;
  logic        parity_err;

  modport master (
    output key_valid, key_in, key_decrypt, sk_ready,
    input  key_ready, sk_valid, subkey_out, sk_round, sk_last, parity_err
  );

  modport slave (
    input  key_valid, key_in, key_decrypt, sk_ready,
    output key_ready, sk_valid, subkey_out, sk_round, sk_last, parity_err
  );
endinterface

// File: rtl/des_key_sched_pc2.sv
// Combinational PC-2 compression of the 56-bit C/D state into a 48-bit subkey.
module des_key_sched_pc2
  import des_pkg::*;
(
  input  logic [1:56] cd_i,
  output logic [1:48] subkey_o
);
  assign subkey_o = pc2(cd_i);
endmodule

// File: rtl/des_key_sched.sv
// DES key-schedule engine: loads a key through PC-1, then streams the 16 round
// subkeys in encrypt (K1..K16) or decrypt (K16..K1) order over valid/ready.
module des_key_sched
  import des_pkg::*;
#(
  parameter bit PARITY_CHECK = 1'b1,
  parameter bit BACK_TO_BACK = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  des_key_sched_if.slave ks_io
);
  state_e      state_q, state_d;
  logic [1:28] c_q, c_d, d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        parityErr_q, parityErr_d;
  logic        keyReady, skValid, skLast;
  logic [3:0]  skRound;
  logic        keyAccept, skFire;
  logic [1:56] pc1Key;
  logic [1:48] subkey;

  assign pc1Key    = pc1(ks_io.key_in);
  assign keyAccept = ks_io.key_valid & keyReady;
  assign skFire    = skValid & ks_io.sk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      parityErr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      parityErr_q <= parityErr_d;
    end
  end

  // Decrypt walks backwards from C16/D16, which equals the raw PC-1 output.
  // A key accepted alongside the final handshake overrides the return to IDLE.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    parityErr_d = parityErr_q;
    if (skFire) begin
      if (cnt_q != 4'd15) begin
        cnt_d = cnt_q + 4'd1;
        if (!mode_q) begin
          c_d = rotl28(c_q, SHIFT[int'(cnt_q) + 2]);
          d_d = rotl28(d_q, SHIFT[int'(cnt_q) + 2]);
        end else begin
          c_d = rotr28(c_q, SHIFT[16 - int'(cnt_q)]);
          d_d = rotr28(d_q, SHIFT[16 - int'(cnt_q)]);
        end
      end else begin
        state_d = IDLE;
      end
    end
    if (keyAccept) begin
      c_d         = ks_io.key_decrypt ? pc1Key[1:28]  : rotl28(pc1Key[1:28], SHIFT[1]);
      d_d         = ks_io.key_decrypt ? pc1Key[29:56] : rotl28(pc1Key[29:56], SHIFT[1]);
      cnt_d       = 4'd0;
      mode_d      = ks_io.key_decrypt;
      state_d     = RUN;
      parityErr_d = PARITY_CHECK & keyParityErr(ks_io.key_in);
    end
  end

  // Round 16 wraps to 4'd0 in both the cnt+1 and 16-cnt forms.
  always_comb begin
    keyReady = 1'b0;
    skValid  = 1'b0;
    skLast   = 1'b0;
    skRound  = 4'd0;
    unique case (state_q)
      IDLE: keyReady = 1'b1;
      RUN: begin
        skValid  = 1'b1;
        skLast   = (cnt_q == 4'd15);
        keyReady = BACK_TO_BACK & (cnt_q == 4'd15) & ks_io.sk_ready;
        skRound  = mode_q ? (4'd0 - cnt_q) : (cnt_q + 4'd1);
      end
    endcase
  end

  des_key_sched_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (subkey)
  );

  assign ks_io.key_ready  = keyReady;
  assign ks_io.sk_valid   = skValid;
  assign ks_io.subkey_out = subkey;
  assign ks_io.sk_round   = skRound;
  assign ks_io.sk_last    = skLast;
  assign ks_io.parity_err = parityErr_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched using the classic 133457799BBCDFF1 key
// schedule; dut_a uses defaults, dut_b disables parity checking and back-to-back.
module tb_des_key_sched;

  localparam logic [63:0] KEY      = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BADP = 64'h133457799BBCDFF0;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [47:0] expK [1:16];

  des_key_sched_if ifa();
  des_key_sched_if ifb();

  des_key_sched dut_a (
    .clk   (clk),
    .rst   (rst),
    .ks_io (ifa.slave)
  );

  des_key_sched #(
    .PARITY_CHECK (1'b0),
    .BACK_TO_BACK (1'b0)
  ) dut_b (
    .clk   (clk),
    .rst   (rst),
    .ks_io (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not terminate");
  end

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({ifa.key_ready, ifa.sk_valid, ifa.sk_last, ifa.parity_err, ifa.subkey_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 48'h0}) begin
      errors++;
      $display("[TB] FAIL reset_a got rdy=%0b v=%0b l=%0b p=%0b k=%h want rdy=1 v=0 l=0 p=0 k=0",
               ifa.key_ready, ifa.sk_valid, ifa.sk_last, ifa.parity_err, ifa.subkey_out);
    end
    checks++;
    if ({ifb.key_ready, ifb.sk_valid, ifb.sk_last, ifb.parity_err, ifb.subkey_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 48'h0}) begin
      errors++;
      $display("[TB] FAIL reset_b got rdy=%0b v=%0b l=%0b p=%0b k=%h want rdy=1 v=0 l=0 p=0 k=0",
               ifb.key_ready, ifb.sk_valid, ifb.sk_last, ifb.parity_err, ifb.subkey_out);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({ifa.key_ready, ifa.sk_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got rdy=%0b v=%0b want rdy=1 v=0", ifa.key_ready, ifa.sk_valid);
    end
  endtask

  task automatic test_encrypt();
    @(negedge clk);
    ifa.sk_ready = 1'b1; ifa.key_in = KEY; ifa.key_decrypt = 1'b0; ifa.key_valid = 1'b1;
    #1;
    checks++;
    if (ifa.key_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL enc_key_ready got %0b want 1", ifa.key_ready);
    end
    @(negedge clk);
    ifa.key_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      checks++;
      if ({ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.subkey_out} !== {1'b1, 4'(i), (i == 16), expK[i]}) begin
        errors++;
        $display("[TB] FAIL enc_k%0d got v=%0b r=%0d l=%0b k=%h want v=1 r=%0d l=%0b k=%h",
                 i, ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.subkey_out, 4'(i), (i == 16), expK[i]);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({ifa.sk_valid, ifa.key_ready, ifa.parity_err} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL enc_end got v=%0b rdy=%0b p=%0b want v=0 rdy=1 p=0", ifa.sk_valid, ifa.key_ready, ifa.parity_err);
    end
  endtask

  task automatic test_decrypt();
    @(negedge clk);
    ifa.sk_ready = 1'b1; ifa.key_in = KEY; ifa.key_decrypt = 1'b1; ifa.key_valid = 1'b1;
    @(negedge clk);
    ifa.key_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      checks++;
      if ({ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.subkey_out} !== {1'b1, 4'(17 - i), (i == 16), expK[17 - i]}) begin
        errors++;
        $display("[TB] FAIL dec_step%0d got v=%0b r=%0d l=%0b k=%h want v=1 r=%0d l=%0b k=%h",
                 i, ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.subkey_out, 4'(17 - i), (i == 16), expK[17 - i]);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (ifa.sk_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dec_end got v=%0b want v=0", ifa.sk_valid);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int cyc;
    @(negedge clk);
    ifa.sk_ready = 1'b0; ifa.key_in = KEY; ifa.key_decrypt = 1'b0; ifa.key_valid = 1'b1;
    @(negedge clk);
    ifa.key_valid = 1'b0;
    idx = 1;
    cyc = 0;
    while (idx <= 16 && cyc < 300) begin
      ifa.sk_ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.subkey_out} !== {1'b1, 4'(idx), (idx == 16), expK[idx]}) begin
        errors++;
        $display("[TB] FAIL bp_cyc%0d got v=%0b r=%0d l=%0b k=%h want v=1 r=%0d l=%0b k=%h",
                 cyc, ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.subkey_out, 4'(idx), (idx == 16), expK[idx]);
      end
      if (ifa.sk_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    ifa.sk_ready = 1'b1;
    checks++;
    if (idx != 17) begin
      errors++;
      $display("[TB] FAIL bp_budget got idx=%0d want 17", idx);
    end
    #1;
    checks++;
    if (ifa.sk_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_end got v=%0b want v=0", ifa.sk_valid);
    end
  endtask

  task automatic test_parity_zero_key();
    @(negedge clk);
    ifa.sk_ready = 1'b1; ifa.key_in = 64'h0; ifa.key_decrypt = 1'b0; ifa.key_valid = 1'b1;
    @(negedge clk);
    ifa.key_valid = 1'b0;
    #1;
    checks++;
    if (ifa.parity_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_parity_a got %0b want 1", ifa.parity_err);
    end
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) #1;
      checks++;
      if ({ifa.sk_valid, ifa.sk_round, ifa.subkey_out} !== {1'b1, 4'(i), 48'h0}) begin
        errors++;
        $display("[TB] FAIL zero_k%0d got v=%0b r=%0d k=%h want v=1 r=%0d k=0",
                 i, ifa.sk_valid, ifa.sk_round, ifa.subkey_out, 4'(i));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ifa.sk_ready = 1'b1; ifa.key_in = 64'h0; ifa.key_decrypt = 1'b0; ifa.key_valid = 1'b1;
    @(negedge clk);
    ifa.key_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      checks++;
      if ({ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.subkey_out} !== {1'b1, 4'(i), (i == 16), 48'h0}) begin
        errors++;
        $display("[TB] FAIL b2b_first_k%0d got v=%0b r=%0d l=%0b k=%h want v=1 r=%0d l=%0b k=0",
                 i, ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.subkey_out, 4'(i), (i == 16));
      end
      if (i == 16) begin
        ifa.key_in = KEY; ifa.key_decrypt = 1'b0; ifa.key_valid = 1'b1;
        #1;
        checks++;
        if (ifa.key_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_key_ready got %0b want 1", ifa.key_ready);
        end
      end
      @(negedge clk);
    end
    ifa.key_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      checks++;
      if ({ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.parity_err, ifa.subkey_out} !== {1'b1, 4'(i), (i == 16), 1'b0, expK[i]}) begin
        errors++;
        $display("[TB] FAIL b2b_second_k%0d got v=%0b r=%0d l=%0b p=%0b k=%h want v=1 r=%0d l=%0b p=0 k=%h",
                 i, ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.parity_err, ifa.subkey_out, 4'(i), (i == 16), expK[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_back_to_back();
    @(negedge clk);
    ifb.sk_ready = 1'b1; ifb.key_in = 64'h0; ifb.key_decrypt = 1'b0; ifb.key_valid = 1'b1;
    @(negedge clk);
    ifb.key_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      checks++;
      if ({ifb.sk_valid, ifb.sk_round, ifb.parity_err, ifb.subkey_out} !== {1'b1, 4'(i), 1'b0, 48'h0}) begin
        errors++;
        $display("[TB] FAIL nob2b_zero_k%0d got v=%0b r=%0d p=%0b k=%h want v=1 r=%0d p=0 k=0",
                 i, ifb.sk_valid, ifb.sk_round, ifb.parity_err, ifb.subkey_out, 4'(i));
      end
      if (i == 16) begin
        ifb.key_in = KEY; ifb.key_decrypt = 1'b0; ifb.key_valid = 1'b1;
        #1;
        checks++;
        if (ifb.key_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL nob2b_last_ready got %0b want 0", ifb.key_ready);
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({ifb.sk_valid, ifb.key_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL nob2b_bubble got v=%0b rdy=%0b want v=0 rdy=1", ifb.sk_valid, ifb.key_ready);
    end
    @(negedge clk);
    ifb.key_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      checks++;
      if ({ifb.sk_valid, ifb.sk_round, ifb.sk_last, ifb.subkey_out} !== {1'b1, 4'(i), (i == 16), expK[i]}) begin
        errors++;
        $display("[TB] FAIL nob2b_k%0d got v=%0b r=%0d l=%0b k=%h want v=1 r=%0d l=%0b k=%h",
                 i, ifb.sk_valid, ifb.sk_round, ifb.sk_last, ifb.subkey_out, 4'(i), (i == 16), expK[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    ifa.sk_ready = 1'b1; ifa.key_in = KEY_BADP; ifa.key_decrypt = 1'b0; ifa.key_valid = 1'b1;
    @(negedge clk);
    ifa.key_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      #1;
      checks++;
      if ({ifa.sk_valid, ifa.sk_round, ifa.parity_err, ifa.subkey_out} !== {1'b1, 4'(i), 1'b1, expK[i]}) begin
        errors++;
        $display("[TB] FAIL rst_pre_k%0d got v=%0b r=%0d p=%0b k=%h want v=1 r=%0d p=1 k=%h",
                 i, ifa.sk_valid, ifa.sk_round, ifa.parity_err, ifa.subkey_out, 4'(i), expK[i]);
      end
      if (i < 7) @(negedge clk);
    end
    ifa.sk_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ifa.sk_valid, ifa.sk_last, ifa.parity_err, ifa.key_ready, ifa.subkey_out} !== {1'b0, 1'b0, 1'b0, 1'b1, 48'h0}) begin
      errors++;
      $display("[TB] FAIL rst_async got v=%0b l=%0b p=%0b rdy=%0b k=%h want v=0 l=0 p=0 rdy=1 k=0",
               ifa.sk_valid, ifa.sk_last, ifa.parity_err, ifa.key_ready, ifa.subkey_out);
    end
    @(negedge clk);
    rst = 1'b0;
    ifa.sk_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ifa.sk_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_release got v=%0b want v=0", ifa.sk_valid);
    end
    ifa.key_in = KEY; ifa.key_decrypt = 1'b0; ifa.key_valid = 1'b1;
    @(negedge clk);
    ifa.key_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      checks++;
      if ({ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.subkey_out} !== {1'b1, 4'(i), (i == 16), expK[i]}) begin
        errors++;
        $display("[TB] FAIL rst_post_k%0d got v=%0b r=%0d l=%0b k=%h want v=1 r=%0d l=%0b k=%h",
                 i, ifa.sk_valid, ifa.sk_round, ifa.sk_last, ifa.subkey_out, 4'(i), (i == 16), expK[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    expK = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
             48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
             48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
             48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    rst = 1'b1;
    ifa.key_valid = 1'b0; ifa.key_in = '0; ifa.key_decrypt = 1'b0; ifa.sk_ready = 1'b0;
    ifb.key_valid = 1'b0; ifb.key_in = '0; ifb.key_decrypt = 1'b0; ifb.sk_ready = 1'b0;
    $display("[TB] starting des_key_sched bench");
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_parity_zero_key();
    test_back_to_back();
    test_no_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
